// File: rtl/time_display_scan_pkg.sv
// Shared constants for the multiplexed time display: segment codes,
// digit positions and the blink field encoding.
package time_disp_pkg;

  // Segment codes, bit order {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [2:0] POS_SEC_ONES  = 3'd0;
  localparam logic [2:0] POS_SEC_TENS  = 3'd1;
  localparam logic [2:0] POS_SEP_SEC   = 3'd2;
  localparam logic [2:0] POS_MIN_ONES  = 3'd3;
  localparam logic [2:0] POS_MIN_TENS  = 3'd4;
  localparam logic [2:0] POS_SEP_MIN   = 3'd5;
  localparam logic [2:0] POS_HOUR_ONES = 3'd6;
  localparam logic [2:0] POS_HOUR_TENS = 3'd7;

  typedef enum logic [1:0] {
    BLINK_NONE  = 2'b00,
    BLINK_HOURS = 2'b01,
    BLINK_MIN   = 2'b10,
    BLINK_SEC   = 2'b11
  } blink_sel_t;

endpackage

// File: rtl/time_display_scan_bcd_to_seg.sv
// Combinational BCD nibble to seven-segment decoder; non-decimal nibbles show "E".
module bcd_to_seg
  import time_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Nibble lookup, anything above 9 falls through to the error glyph
  always_comb begin
    seg = SEG_E;
    case (nibble)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_E;
    endcase
  end

endmodule

// File: rtl/time_display_scan.sv
// Eight-digit HH-MM-SS scanner: prescaled digit tick, per-frame shadowed
// inputs, field blinking and a blank override on registered outputs.
module time_display_scan
  import time_disp_pkg::*;
#(
  parameter int DIV         = 100000,
  parameter int BLINK_TICKS = 500
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic [7:0] hours_bcd,
  input  logic [7:0] min_bcd,
  input  logic [7:0] sec_bcd,
  input  logic [1:0] blink_sel,
  input  logic       blank,
  output logic [6:0] segment,
  output logic [7:0] ss_digit
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(DIV - 1);
  localparam logic [PW-1:0] PRE_ONE    = PW'(1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [BW-1:0] BLINK_ONE  = BW'(1);

  logic [PW-1:0] prescale;
  logic          tick;
  logic [2:0]    index;
  logic [BW-1:0] blink_cnt;
  logic          blink_on;
  logic [7:0]    hours_sh, min_sh, sec_sh;
  blink_sel_t    sel_sh;

  logic [3:0]    nibble;
  logic          is_sep;
  logic          lead_zero;
  blink_sel_t    field;
  logic [6:0]    dec_seg;
  logic [6:0]    next_seg;

  // With DIV=1 the prescaler sits at 0 and the tick is permanently high
  assign tick = (prescale == PRE_LAST);

  // Prescaler, digit index, blink timing and frame-boundary shadow capture
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      prescale  <= {PW{1'b0}};
      index     <= 3'd0;
      blink_cnt <= {BW{1'b0}};
      blink_on  <= 1'b1;
      hours_sh  <= 8'h00;
      min_sh    <= 8'h00;
      sec_sh    <= 8'h00;
      sel_sh    <= BLINK_NONE;
    end else if (tick) begin
      prescale <= {PW{1'b0}};
      index    <= index + 3'd1;
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= {BW{1'b0}};
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BLINK_ONE;
      end
      if (index == POS_HOUR_TENS) begin
        hours_sh <= hours_bcd;
        min_sh   <= min_bcd;
        sec_sh   <= sec_bcd;
        sel_sh   <= blink_sel_t'(blink_sel);
      end else begin
        hours_sh <= hours_sh;
        min_sh   <= min_sh;
        sec_sh   <= sec_sh;
        sel_sh   <= sel_sh;
      end
    end else begin
      prescale <= prescale + PRE_ONE;
    end
  end

  // Pick the nibble and field owning the current digit position
  always_comb begin
    nibble    = 4'd0;
    is_sep    = 1'b0;
    lead_zero = 1'b0;
    field     = BLINK_NONE;
    case (index)
      POS_SEC_ONES:  begin nibble = sec_sh[3:0];   field = BLINK_SEC;   end
      POS_SEC_TENS:  begin nibble = sec_sh[7:4];   field = BLINK_SEC;   end
      POS_SEP_SEC:   is_sep = 1'b1;
      POS_MIN_ONES:  begin nibble = min_sh[3:0];   field = BLINK_MIN;   end
      POS_MIN_TENS:  begin nibble = min_sh[7:4];   field = BLINK_MIN;   end
      POS_SEP_MIN:   is_sep = 1'b1;
      POS_HOUR_ONES: begin nibble = hours_sh[3:0]; field = BLINK_HOURS; end
      POS_HOUR_TENS: begin
        nibble    = hours_sh[7:4];
        field     = BLINK_HOURS;
        lead_zero = (hours_sh[7:4] == 4'd0);
      end
      default:       is_sep = 1'b1;
    endcase
  end

  bcd_to_seg u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  // Separators override everything; blink and leading zero blank the digit
  always_comb begin
    next_seg = dec_seg;
    if (is_sep) begin
      next_seg = SEG_DASH;
    end else if (lead_zero ||
                 (!blink_on && (sel_sh != BLINK_NONE) && (field == sel_sh))) begin
      next_seg = SEG_BLANK;
    end else begin
      next_seg = dec_seg;
    end
  end

  // Output registers: one clock behind the index, forced dark while blank is high
  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      segment  <= SEG_BLANK;
      ss_digit <= 8'hFF;
    end else if (blank) begin
      segment  <= SEG_BLANK;
      ss_digit <= 8'hFF;
    end else begin
      segment  <= next_seg;
      ss_digit <= ~(8'd1 << index);
    end
  end

endmodule

// File: tb/tb_time_display_scan.sv
// Directed bench for time_display_scan with DIV=2, BLINK_TICKS=4; edges are
// counted from reset release so every digit slot is known in advance.
module tb_time_display_scan;

  localparam logic [6:0] S0  = 7'b1000000;
  localparam logic [6:0] S1  = 7'b1111001;
  localparam logic [6:0] S2  = 7'b0100100;
  localparam logic [6:0] S3  = 7'b0110000;
  localparam logic [6:0] S4  = 7'b0011001;
  localparam logic [6:0] S5  = 7'b0010010;
  localparam logic [6:0] S6  = 7'b0000010;
  localparam logic [6:0] S9  = 7'b0010000;
  localparam logic [6:0] SD  = 7'b0111111;
  localparam logic [6:0] SE  = 7'b0000110;
  localparam logic [6:0] SBL = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] hours, mins, secs;
  logic [1:0] blink_sel;
  logic       blank;
  logic [6:0] segment;
  logic [7:0] ss_digit;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  time_display_scan #(.DIV(2), .BLINK_TICKS(4)) dut (
    .CLK100MHZ (clk),
    .reset     (reset),
    .hours_bcd (hours),
    .min_bcd   (mins),
    .sec_bcd   (secs),
    .blink_sel (blink_sel),
    .blank     (blank),
    .segment   (segment),
    .ss_digit  (ss_digit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after posedge number e (counted from release), sampling at negedge
  task automatic at_edge(input int e);
    repeat (e - edge_n) @(posedge clk);
    edge_n = e;
    @(negedge clk);
  endtask

  task automatic dig(input int e, input int k, input logic [6:0] exp_seg);
    logic [7:0] exp_an;
    exp_an = ~(8'd1 << k);
    at_edge(e);
    chk($sformatf("seg e%0d d%0d", e, k), {1'b0, segment}, {1'b0, exp_seg});
    chk($sformatf("an e%0d d%0d", e, k), ss_digit, exp_an);
  endtask

  task automatic dark(input string tag);
    chk({tag, " seg"}, {1'b0, segment}, {1'b0, SBL});
    chk({tag, " an"}, ss_digit, 8'hFF);
  endtask

  logic [6:0] f1 [8];

  initial begin
    f1 = '{S6, S5, SD, S4, S3, SD, S2, S1};
    reset     = 1'b0;
    hours     = 8'h12;
    mins      = 8'h34;
    secs      = 8'h56;
    blink_sel = 2'b00;
    blank     = 1'b0;

    repeat (3) @(negedge clk);
    dark("in reset");
    reset  = 1'b1;
    edge_n = 0;

    // Frame 0 shows cleared shadows; digit 0 holds through the tick edge
    dig(1, 0, S0);
    dig(2, 0, S0);
    dig(3, 1, S0);
    dig(15, 7, SBL);

    // Frame 1: 12-34-56 captured at the wrap; hours change mid-frame stays hidden
    dig(17, 0, f1[0]);
    at_edge(18);
    hours = 8'h09;
    for (int k = 1; k < 8; k++) dig(17 + 2 * k, k, f1[k]);

    // Frame 2: leading hour zero blanked
    at_edge(34);
    mins = 8'h3A;
    secs = 8'h59;
    dig(39, 3, S4);
    dig(45, 6, S9);
    dig(47, 7, SBL);

    // Frame 3: invalid nibble, seconds change at index 3 deferred
    dig(49, 0, S9);
    dig(51, 1, S5);
    at_edge(54);
    secs = 8'h00;
    dig(55, 3, SE);
    dig(57, 4, S3);

    // Frame 4: new seconds visible; minutes blink requested for next frame
    dig(65, 0, S0);
    at_edge(66);
    blink_sel = 2'b10;
    mins      = 8'h45;
    dig(67, 1, S0);
    dig(71, 3, SE);
    dig(73, 4, S3);

    // Frame 5: phase on for digits 0-3, off for 4-7; only minutes blank
    dig(83, 1, S0);
    dig(87, 3, S5);
    dig(88, 3, S5);
    dig(89, 4, SBL);
    dig(91, 5, SD);
    dig(93, 6, S9);

    // Blank pulse for three clocks, scan keeps advancing underneath
    at_edge(98);
    blank = 1'b1;
    at_edge(99);
    dark("blank e99");
    at_edge(100);
    dark("blank e100");
    at_edge(101);
    dark("blank e101");
    blank = 1'b0;
    dig(102, 2, SD);

    // Reset at index 5 darkens outputs without waiting for a clock
    at_edge(106);
    reset = 1'b0;
    #1;
    dark("async reset");
    repeat (2) @(negedge clk);
    reset  = 1'b1;
    edge_n = 0;
    dig(1, 0, S0);
    dig(2, 0, S0);
    dig(3, 1, S0);
    dig(13, 6, S0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_display_scan.md
TIME_DISPLAY_SCAN -- requirements
Module: time_display_scan

Interface
REQ-001 Parameter DIV, default 100000, CLK100MHZ cycles per digit tick (min 1).
REQ-002 Parameter BLINK_TICKS, default 500, digit ticks per blink-phase toggle (min 1).
REQ-003 CLK100MHZ  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 hours_bcd  input  8  hour, two BCD nibbles, [7:4] tens, [3:0] ones.
REQ-006 min_bcd  input  8  minute, two BCD nibbles.
REQ-007 sec_bcd  input  8  second, two BCD nibbles.
REQ-008 blink_sel  input  2  field being set: 00 none, 01 hours, 10 minutes, 11 seconds.
REQ-009 blank  input  1  display off when high.
REQ-010 segment  output  7  {g,f,e,d,c,b,a}, active-low, registered.
REQ-011 ss_digit  output  8  digit anodes, active-low, one-hot-low, registered; bit 0 is rightmost.

Function
REQ-012 The prescaler SHALL count 0..DIV-1 and assert a one-cycle tick on the cycle it wraps to 0.
REQ-013 The 3-bit digit index SHALL advance on each tick and wrap from 7 to 0.
REQ-014 Digit map SHALL be:
- 0 sec ones; 1 sec tens; 2 "-"
- 3 min ones; 4 min tens; 5 "-"
- 6 hour ones; 7 hour tens
REQ-015 Shadow registers for hours, minutes, seconds and blink_sel SHALL load on the tick where the index wraps 7->0; mid-frame input changes SHALL not appear until the next frame.
REQ-016 segment and ss_digit SHALL update exactly one clock after the tick that selects the digit.
REQ-017 Decoder values:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- "-"=0111111, "E"=0000110, blank=1111111
REQ-018 Any nibble greater than 9 SHALL display "E".
REQ-019 Hour tens nibble equal to 0 SHALL display blank.
REQ-020 The blink counter SHALL count digit ticks and toggle the blink phase every BLINK_TICKS ticks.
REQ-021 During the off phase, both digits of the field selected by the shadowed blink_sel SHALL show blank; separators are never blinked.
REQ-022 blank=1 SHALL force ss_digit=11111111 on the next clock; the prescaler, index and blink counter SHALL keep running.
REQ-023 On the cycle blank falls, output SHALL resume at the current index without restarting the frame.
REQ-024 With DIV=1, a tick SHALL occur every cycle and each digit SHALL be driven for exactly one cycle.

Reset
REQ-025 reset low SHALL asynchronously clear:
- prescaler, digit index and blink counter to 0
- shadow registers to 0
- blink phase to on (visible)
REQ-026 During reset, segment SHALL be 1111111 and ss_digit SHALL be 11111111.
REQ-027 Reset asserted mid-frame SHALL abort the scan; after release, the first tick SHALL select digit 1.

Structure
REQ-028 Package time_disp_pkg SHALL hold:
- the segment constants for 0-9, "-", "E" and blank
- the digit-position constants
- the blink_sel encoding
REQ-029 A combinational sub-module bcd_to_seg SHALL map a 4-bit nibble to segment code per REQ-017/018; it is instantiated once, on the selected nibble.
REQ-030 All state SHALL live in time_display_scan; there SHALL be no derived or gated clocks.

Verification (DIV=2, BLINK_TICKS=4)
REQ-031 Frame display check:
- stimulus: release reset with hours=8'h12, min=8'h34, sec=8'h56, blink_sel=00; run one full frame
- response: digits 0..7 show 6,5,-,4,3,-,2,1, each with the correct single low ss_digit bit, one clock after its tick
REQ-032 Leading blank and invalid nibble:
- stimulus: hours=8'h09, then min=8'h3A
- response: digit 7 shows blank; in the next frame, digit 3 shows "E"
REQ-033 Blink:
- stimulus: blink_sel=10 with min=8'h45
- response: digits 3 and 4 alternate between 5/4 and blank every 4 ticks; all other digits are steady
REQ-034 Frame coherency:
- stimulus: change sec from 8'h59 to 8'h00 while the index is 3
- response: seconds digits keep 9/5 until the next wrap, then show 0/0
REQ-035 Blank and reset:
- stimulus: pulse blank for 3 cycles; later, assert reset at index 5
- response: ss_digit=FF one cycle after blank rises, and scan resumes at the advanced index; on reset, outputs go immediately to 7F/FF and the first post-release tick selects digit 1
